// File: rtl/count_bits_pkg.sv
// count_bits_pkg: shared types and helpers for the count_bits_pipe unit.
//   mode_e        : per-beat operation (zeros, ones, leading zeros, trailing zeros)
//   nibble_cnt_t  : 3-bit count for a single nibble (0..4)
//   nibble_info   : zero / leading-zero / trailing-zero counts of a nibble
//   csa_3_2       : 3:2 carry-save compressor on CSA_MAX_W-bit words
package count_bits_pkg;

  typedef enum logic [1:0] {
    MODE_CZ = 2'd0,
    MODE_CO = 2'd1,
    MODE_LZ = 2'd2,
    MODE_TZ = 2'd3
  } mode_e;

  typedef logic [2:0] nibble_cnt_t;

  typedef struct packed {
    nibble_cnt_t zc;
    nibble_cnt_t lz;
    nibble_cnt_t tz;
  } nibble_info_t;

  // Wide enough for the largest count (W=256 -> 9 bits); callers truncate
  // back to their own CNT_W, which is safe because carry-save arithmetic is
  // exact modulo 2^CNT_W and the true total always fits in CNT_W.
  localparam int CSA_MAX_W = 16;
  typedef logic [CSA_MAX_W-1:0] csa_word_t;

  typedef struct packed {
    csa_word_t sum;
    csa_word_t carry;
  } csa_pair_t;

  function automatic nibble_info_t nibble_info(input logic [3:0] nib);
    nibble_info_t info;
    nibble_cnt_t  ones;
    ones = nibble_cnt_t'(nib[0]) + nibble_cnt_t'(nib[1]) +
           nibble_cnt_t'(nib[2]) + nibble_cnt_t'(nib[3]);
    info.zc = 3'd4 - ones;
    if (nib[3])      info.lz = 3'd0;
    else if (nib[2]) info.lz = 3'd1;
    else if (nib[1]) info.lz = 3'd2;
    else if (nib[0]) info.lz = 3'd3;
    else             info.lz = 3'd4;
    if (nib[0])      info.tz = 3'd0;
    else if (nib[1]) info.tz = 3'd1;
    else if (nib[2]) info.tz = 3'd2;
    else if (nib[3]) info.tz = 3'd3;
    else             info.tz = 3'd4;
    return info;
  endfunction

  function automatic csa_pair_t csa_3_2(input csa_word_t x, input csa_word_t y,
                                        input csa_word_t z);
    csa_pair_t p;
    p.sum   = x ^ y ^ z;
    p.carry = ((x & y) | (x & z) | (y & z)) << 1;
    return p;
  endfunction

endpackage

// File: rtl/count_bits_csa_tree.sv
// count_bits_csa_tree: combinational carry-save reduction of N CNT_W-bit
// operands down to a redundant (a, b) pair whose sum equals the operand sum
// modulo 2^CNT_W.
//   i_ops : N operands packed, operand k at [k*CNT_W +: CNT_W]
//   o_a   : carry-save sum word
//   o_b   : carry-save carry word
module count_bits_csa_tree
  import count_bits_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 6
) (
  input  logic [N*CNT_W-1:0] i_ops,
  output logic [CNT_W-1:0]   o_a,
  output logic [CNT_W-1:0]   o_b
);

  csa_word_t w_a;
  csa_word_t w_b;
  csa_pair_t w_pair;
  logic      w_unused_hi;

  // Each 3:2 stage folds one more operand into the running pair; no carry
  // propagation happens until the final adder in the pipeline.
  always_comb begin
    w_a    = csa_word_t'(i_ops[CNT_W-1:0]);
    w_b    = csa_word_t'(i_ops[2*CNT_W-1:CNT_W]);
    w_pair = '0;
    for (int i = 2; i < N; i++) begin
      w_pair = csa_3_2(w_a, w_b, csa_word_t'(i_ops[i*CNT_W +: CNT_W]));
      w_a    = w_pair.sum;
      w_b    = w_pair.carry;
    end
  end

  assign o_a = w_a[CNT_W-1:0];
  assign o_b = w_b[CNT_W-1:0];

  // Bits above CNT_W are modular overflow and intentionally discarded.
  assign w_unused_hi = ^{w_a[CSA_MAX_W-1:CNT_W], w_b[CSA_MAX_W-1:CNT_W], w_pair};

endmodule

// File: rtl/count_bits_pipe.sv
// count_bits_pipe: two-stage pipelined bit counter with valid/ready flow.
// Optional accumulator enabled by defining COUNT_BITS_PIPE_ACC_EN.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_vld/in_rdy       : input handshake; in_mode selects operation, in_x operand
//   out_vld/out_rdy     : output handshake; out_y count (0..W), out_mode echo
//   in_last             : (ACC_EN) marks the last beat of a packet
//   out_acc/out_acc_vld : (ACC_EN) saturating packet total, valid on last beat
// Handshake: a beat moves when valid and ready are both high on a rising
// edge; a valid beat is held stable until it moves, and ready may depend
// combinationally on the downstream ready.
module count_bits_pipe
  import count_bits_pkg::*;
#(
  parameter  int W     = 32,
  localparam int CNT_W = $clog2(W) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [1:0]       in_mode,
  input  logic [W-1:0]     in_x,
`ifdef COUNT_BITS_PIPE_ACC_EN
  input  logic             in_last,
  output logic [CNT_W+15:0] out_acc,
  output logic             out_acc_vld,
`endif
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [CNT_W-1:0] out_y,
  output logic [1:0]       out_mode
);

  localparam int N = W / 4;

  mode_e              w_mode;
  nibble_info_t       w_info [N];
  logic [N*CNT_W-1:0] w_ops;
  logic [CNT_W-1:0]   w_tree_a;
  logic [CNT_W-1:0]   w_tree_b;
  logic [CNT_W-1:0]   w_lz;
  logic [CNT_W-1:0]   w_tz;
  logic               w_lz_found;
  logic               w_tz_found;
  logic               w_s1_adv;
  logic               w_s2_adv;

  logic               r_s1_vld;
  logic [CNT_W-1:0]   r_s1_a;
  logic [CNT_W-1:0]   r_s1_b;
  logic [1:0]         r_s1_mode;
  logic               r_s2_vld;
  logic [CNT_W-1:0]   r_s2_y;
  logic [1:0]         r_s2_mode;

  assign w_mode = mode_e'(in_mode);

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_info[i] = nibble_info(in_x[4*i +: 4]);
      if (w_mode == MODE_CO)
        w_ops[i*CNT_W +: CNT_W] = CNT_W'(3'd4 - w_info[i].zc);
      else
        w_ops[i*CNT_W +: CNT_W] = CNT_W'(w_info[i].zc);
    end
  end

  count_bits_csa_tree #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_tree (
    .i_ops (w_ops),
    .o_a   (w_tree_a),
    .o_b   (w_tree_b)
  );

  // Priority scans: every all-zero nibble ahead of the first nonzero one
  // contributes 4; the first nonzero nibble contributes its own lz/tz.
  // An all-zero word therefore totals 4*N = W.
  always_comb begin
    w_lz       = '0;
    w_lz_found = 1'b0;
    for (int i = N-1; i >= 0; i--) begin
      if (!w_lz_found) begin
        w_lz = w_lz + CNT_W'(w_info[i].lz);
        if (in_x[4*i +: 4] != 4'd0) w_lz_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_tz       = '0;
    w_tz_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!w_tz_found) begin
        w_tz = w_tz + CNT_W'(w_info[i].tz);
        if (in_x[4*i +: 4] != 4'd0) w_tz_found = 1'b1;
      end
    end
  end

  // Stall chain: a stage may load when it is empty or its contents move on.
  assign w_s2_adv = !r_s2_vld || out_rdy;
  assign w_s1_adv = !r_s1_vld || w_s2_adv;
  assign in_rdy   = w_s1_adv;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
    end else begin
      if (w_s1_adv) r_s1_vld <= in_vld;
      if (w_s2_adv) r_s2_vld <= r_s1_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (w_s1_adv && in_vld) begin
      r_s1_mode <= in_mode;
      case (w_mode)
        MODE_LZ: begin r_s1_a <= w_lz;     r_s1_b <= '0;       end
        MODE_TZ: begin r_s1_a <= w_tz;     r_s1_b <= '0;       end
        default: begin r_s1_a <= w_tree_a; r_s1_b <= w_tree_b; end
      endcase
    end
    if (w_s2_adv && r_s1_vld) begin
      r_s2_y    <= r_s1_a + r_s1_b;
      r_s2_mode <= r_s1_mode;
    end
  end

  assign out_vld  = r_s2_vld;
  assign out_y    = r_s2_y;
  assign out_mode = r_s2_mode;

`ifdef COUNT_BITS_PIPE_ACC_EN
  logic                r_s1_last;
  logic                r_s2_last;
  logic [CNT_W+15:0]   r_acc;
  logic [CNT_W+16:0]   w_acc_ext;
  logic [CNT_W+15:0]   w_acc_sum;
  logic                w_out_xfer;

  always_ff @(posedge clk) begin
    if (w_s1_adv && in_vld)   r_s1_last <= in_last;
    if (w_s2_adv && r_s1_vld) r_s2_last <= r_s1_last;
  end

  assign w_out_xfer = r_s2_vld && out_rdy;
  assign w_acc_ext  = {1'b0, r_acc} + (CNT_W+17)'(r_s2_y);
  assign w_acc_sum  = w_acc_ext[CNT_W+16] ? '1 : w_acc_ext[CNT_W+15:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_out_xfer) begin
      r_acc <= r_s2_last ? '0 : w_acc_sum;
    end
  end

  // The total including the transferring beat is presented combinationally.
  assign out_acc     = w_acc_sum;
  assign out_acc_vld = w_out_xfer && r_s2_last;
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && in_vld)
      assert (!$isunknown(in_mode)) else $error("in_mode unknown while in_vld");
  end
`endif

endmodule

// File: tb/tb_count_bits_pipe.sv
module tb_count_bits_pipe;

  localparam int W   = 32;
  localparam int WW  = 256;
  localparam int CW  = $clog2(W) + 1;
  localparam int CWW = $clog2(WW) + 1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           in_vld  = 1'b0;
  logic [1:0]     in_mode = 2'd0;
  logic [W-1:0]   in_x    = '0;
  logic [WW-1:0]  in_xw   = '0;
  logic           in_last = 1'b0;
  logic           out_rdy = 1'b1;
  logic           in_rdy, in_rdy_w, out_vld, out_vld_w;
  logic [CW-1:0]  out_y;
  logic [CWW-1:0] out_y_w;
  logic [1:0]     out_mode, out_mode_w;
`ifdef COUNT_BITS_PIPE_ACC_EN
  logic [CW+15:0]  out_acc;
  logic            out_acc_vld;
  logic [CWW+15:0] out_acc_w;
  logic            out_acc_vld_w;
`endif

  count_bits_pipe #(.W(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_mode(in_mode), .in_x(in_x),
`ifdef COUNT_BITS_PIPE_ACC_EN
    .in_last(in_last), .out_acc(out_acc), .out_acc_vld(out_acc_vld),
`endif
    .out_vld(out_vld), .out_rdy(out_rdy), .out_y(out_y), .out_mode(out_mode)
  );

  count_bits_pipe #(.W(WW)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy_w),
    .in_mode(in_mode), .in_x(in_xw),
`ifdef COUNT_BITS_PIPE_ACC_EN
    .in_last(in_last), .out_acc(out_acc_w), .out_acc_vld(out_acc_vld_w),
`endif
    .out_vld(out_vld_w), .out_rdy(out_rdy), .out_y(out_y_w), .out_mode(out_mode_w)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: held low
  logic [16:0] exp_q[$];    // {last, mode, count}
  logic [16:0] exp_w_q[$];
  logic [16:0] e, ew;
  logic        hold_prev = 1'b0;
  logic [15:0] held;
  longint      acc_m = 0;
  localparam longint ACC_MAX = (64'd1 << (CW + 16)) - 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: counts straight from the bit-level definitions.
  function automatic int ref_count(input logic [255:0] x, input int w, input logic [1:0] m);
    int n;
    n = 0;
    case (m)
      2'd0: n = w - $countones(x);
      2'd1: n = $countones(x);
      2'd2: for (int i = w - 1; i >= 0 && x[i] == 1'b0; i--) n++;
      default: for (int i = 0; i < w && x[i] == 1'b0; i++) n++;
    endcase
    return n;
  endfunction

  // ---------------- downstream ready ----------------
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_rdy = 1'b1;
      1:       out_rdy = 1'($urandom_range(0, 1));
      default: out_rdy = 1'b0;
    endcase
  end

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 after the beat has transferred.
  task automatic send(input logic [1:0] m, input logic [W-1:0] x, input logic last);
    int waited;
    logic [WW-1:0] xw;
    int r;
    waited = 0;
    for (int k = 0; k < WW / 32; k++) xw[32*k +: 32] = $urandom;
    r = $urandom_range(0, 9);
    if (r == 0) xw = '0;
    else if (r == 1) xw = '1;
    else if (r == 2) xw = WW'(1) << $urandom_range(0, WW - 1);
    in_vld = 1'b1; in_mode = m; in_x = x; in_xw = xw; in_last = last;
    while (1) begin
      @(negedge clk);
      if (in_rdy && in_rdy_w) break;
      waited++;
      if (waited > 200) begin
        checks++; errors++;
        $display("FAIL send_timeout: got in_rdy=0 for %0d cycles required 1", waited);
        @(posedge clk); #1; in_vld = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    exp_q.push_back({last, m, 14'(ref_count({{(256-W){1'b0}}, x}, W, m))});
    exp_w_q.push_back({last, m, 14'(ref_count(xw, WW, m))});
    @(posedge clk); #1;
    in_vld = 1'b0;
  endtask

  task automatic send_rand(input int n);
    logic [W-1:0] x;
    int r;
    for (int i = 0; i < n; i++) begin
      x = $urandom;
      r = $urandom_range(0, 7);
      if (r == 0) x = '0;
      else if (r == 1) x = '1;
      else if (r == 2) x = W'(1) << $urandom_range(0, W - 1);
      send(2'($urandom_range(0, 3)), x, $urandom_range(0, 3) == 0);
    end
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((exp_q.size() != 0 || exp_w_q.size() != 0) && c < 2000) begin
      @(posedge clk); #1; c++;
    end
    if (c >= 2000) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size() + exp_w_q.size());
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
      acc_m = 0;
    end else begin
      if (hold_prev) begin
        check("hold_vld", longint'(out_vld), 1);
        check("hold_data", longint'({out_mode, 14'(out_y)}), longint'(held));
      end
      hold_prev = out_vld && !out_rdy;
      held = {out_mode, 14'(out_y)};
      if (out_vld && out_rdy) begin
        n_out++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out: got out_y=%0d expected no output", out_y);
        end else begin
          e = exp_q.pop_front();
          check("result", longint'({out_mode, 14'(out_y)}), longint'(e[15:0]));
`ifdef COUNT_BITS_PIPE_ACC_EN
          acc_m = acc_m + longint'(out_y);
          if (acc_m > ACC_MAX) acc_m = ACC_MAX;
          check("acc_vld", longint'(out_acc_vld), longint'(e[16]));
          if (e[16]) begin
            check("acc_total", longint'(out_acc), acc_m);
            acc_m = 0;
          end
`endif
        end
      end
      if (out_vld_w && out_rdy) begin
        if (exp_w_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out_w: got out_y=%0d expected no output", out_y_w);
        end else begin
          ew = exp_w_q.pop_front();
          check("result_w256", longint'({out_mode_w, 14'(out_y_w)}), longint'(ew[15:0]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int base;
  initial begin
    rdy_mode = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_vld", longint'(out_vld), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_rdy", longint'(in_rdy), 1);
    @(posedge clk); #1;

    // Directed: first result appears two cycles after the transfer.
    send(2'd0, 32'h0000_00FF, 1'b0);
    @(negedge clk);
    check("latency_c1", longint'(out_vld), 0);
    @(negedge clk);
    check("latency_c2", longint'(out_vld), 1);
    @(posedge clk); #1;
    send(2'd0, 32'h0000_0000, 1'b0);
    send(2'd0, 32'hFFFF_FFFF, 1'b0);
    send(2'd2, 32'h0001_0000, 1'b0);
    send(2'd3, 32'h0001_0000, 1'b0);
    send(2'd2, 32'h0000_0000, 1'b0);
    send(2'd3, 32'h0000_0000, 1'b0);
    send(2'd1, 32'hA5A5_A5A5, 1'b0);
    send(2'd1, 32'hFFFF_FFFF, 1'b0);
    send(2'd1, 32'h0000_0000, 1'b0);
    send(2'd2, 32'hFFFF_FFFF, 1'b0);
    send(2'd3, 32'h8000_0000, 1'b1);
    drain();

    // Backpressure: fill both stages, hold, then release.
    rdy_mode = 2;
    @(posedge clk); #1;
    send_rand(2);
    @(negedge clk);
    check("stall_in_rdy", longint'(in_rdy), 0);
    repeat (3) @(posedge clk);
    #1;
    rdy_mode = 0;
    send_rand(6);
    drain();

    // Reset with two beats in flight.
    send_rand(2);
    rst_n = 1'b0;
    exp_q.delete();
    exp_w_q.delete();
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_flush_out_vld", longint'(out_vld), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    base = n_out;
    @(negedge clk);
    check("rst_release_in_rdy", longint'(in_rdy), 1);
    @(posedge clk); #1;
    send(2'd1, 32'h0000_0F0F, 1'b1);
    drain();
    repeat (5) @(posedge clk);
    #1;
    check("rst_single_output", longint'(n_out - base), 1);

    // Accumulator packets: 4 + 8 + 16 = 28, then a fresh packet.
    send(2'd1, 32'h0000_000F, 1'b0);
    send(2'd1, 32'h0000_00FF, 1'b0);
    send(2'd1, 32'h0000_FFFF, 1'b1);
    send(2'd1, 32'h0000_0007, 1'b1);
    drain();

    // Random traffic with random backpressure.
    rdy_mode = 1;
    send_rand(400);
    drain();
    rdy_mode = 0;
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
